load_fill_ctrl: RTL
===================

LOAD_FILL_CTRL -- requirements
Module: load_fill_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYC, default 255: maximum FETCH cycles before abort, range 1..255, 8-bit counter.
REQ-002 Port clk, in, 1: single clock; all state updates on posedge clk.
REQ-003 Port rst, in, 1: reset, synchronous and active-high.
REQ-004 Port req_valid, in, 1: load lookup request.
REQ-005 Port req_ready, out, 1: high only in IDLE.
REQ-006 Port req_addr, in, 10: byte address.
REQ-007 Port req_size, in, 2: 0 byte, 1 halfword, 2 word, 3 illegal.
REQ-008 Port vr_addr, out, 10: valid-RAM lookup/write address.
REQ-009 Port vr_size, out, 2: valid-RAM access size.
REQ-010 Port vr_write, out, 1: valid-RAM set strobe.
REQ-011 Port vr_valid, in, 4: valid-RAM outputs; bit0 is the byte at vr_addr, bit3 is addr+3.
REQ-012 Port mem_req, out, 1: fill request to backing memory.
REQ-013 Port mem_addr, out, 10: fill address.
REQ-014 Port mem_size, out, 2: fill size.
REQ-015 Port mem_ack, in, 1: fill complete.
REQ-016 Port done, out, 1: one-cycle completion pulse.
REQ-017 Port hit, out, 1: qualifies done; high means no fill was needed.
REQ-018 Port err, out, 1: qualifies done; high means illegal size or timeout.

Function
REQ-019 States SHALL be IDLE, LOOKUP, CHECK, FETCH, WRITE, DONE; all outputs SHALL be registered.
REQ-020 Accept SHALL occur on req_valid&&req_ready; req_addr and req_size latch at that edge and drive vr_*/mem_* until return to IDLE.
REQ-021 IDLE->LOOKUP on accept with size 0..2; IDLE->DONE with err=1 on size 3, with no valid-RAM or memory activity.
REQ-022 LOOKUP SHALL last exactly one cycle, presenting vr_addr/vr_size so the valid RAM registers its outputs at the next posedge.
REQ-023 CHECK SHALL sample vr_valid against mask 0001/0011/1111 for byte/half/word; all masked bits set -> DONE with hit=1; otherwise -> FETCH.
REQ-024 Hit latency SHALL be fixed: done asserts in the 3rd cycle after accept.
REQ-025 FETCH SHALL hold mem_req=1 until mem_ack is sampled high, then -> WRITE with mem_req=0 in the following cycle.
REQ-026 mem_ack outside FETCH SHALL be ignored.
REQ-027 FETCH SHALL count cycles; at TIMEOUT_CYC cycles without mem_ack -> DONE with err=1, mem_req dropped, no vr_write.
REQ-028 mem_ack on the same edge the count reaches TIMEOUT_CYC SHALL win (-> WRITE).
REQ-029 WRITE SHALL assert vr_write for exactly one cycle, then -> DONE with hit=0, err=0.
REQ-030 DONE SHALL assert done for one cycle, then -> IDLE; hit and err SHALL be 0 whenever done=0.
REQ-031 Address wrap (addr+1..+3 beyond 1023) SHALL wrap modulo 1024; req_addr passes unmodified.
REQ-032 req_valid while busy SHALL be ignored.

Reset
REQ-033 rst SHALL force IDLE, with req_ready=1 and all other outputs 0, at the next posedge.
REQ-034 rst SHALL cancel any operation mid-flight: no done pulse, no vr_write, mem_req low from the next edge.

Configuration
REQ-035 With LOAD_FILL_STATS_EN defined, 16-bit outputs hit_cnt and miss_cnt SHALL be added:
- counts increment on done&&hit and on done&&!hit&&!err respectively;
- counts saturate at 0xFFFF;
- counts clear on rst.
REQ-036 Without LOAD_FILL_STATS_EN, those ports and counters SHALL not exist; all other behaviour is identical.

Verification
REQ-037 Reset, then byte req addr 0x010 with vr_valid=0000 -> mem_req; mem_ack after 4 cycles -> one vr_write pulse, done=1, hit=0.
REQ-038 Halfword req addr 0x020 with vr_valid=0011 -> done 3 cycles after accept, hit=1, mem_req never high.
REQ-039 Word req addr 0x3FE with vr_valid=0111 -> FETCH with mem_addr=0x3FE, mem_size=2; after ack -> done, hit=0.
REQ-040 req_size=3 -> done=1, err=1 one cycle after accept, with no vr_write and no mem_req.
REQ-041 TIMEOUT_CYC=4 with mem_ack held low -> done, err=1 after 4 FETCH cycles; separately, ack on the 4th cycle -> WRITE.
REQ-042 rst asserted during FETCH -> mem_req=0 next cycle, no done; with LOAD_FILL_STATS_EN, counts are 0.

Source files
------------

// File: rtl/load_fill_ctrl.sv
// Load lookup / fill sequencer: checks the valid RAM for a request and fetches from memory on a miss.
// Optional LOAD_FILL_STATS_EN adds saturating hit_cnt/miss_cnt outputs.
module load_fill_ctrl #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [9:0] req_addr,
    input  logic [1:0] req_size,
    output logic [9:0] vr_addr,
    output logic [1:0] vr_size,
    output logic       vr_write,
    input  logic [3:0] vr_valid,
    output logic       mem_req,
    output logic [9:0] mem_addr,
    output logic [1:0] mem_size,
    input  logic       mem_ack,
    output logic       done,
    output logic       hit,
    output logic       err
`ifdef LOAD_FILL_STATS_EN
    ,
    output logic [15:0] hit_cnt,
    output logic [15:0] miss_cnt
`endif
);

    // state  | meaning
    // IDLE   | waiting for a request, req_ready high
    // LOOKUP | address presented to the valid RAM
    // CHECK  | valid bits sampled against the size mask
    // FETCH  | mem_req held until mem_ack or timeout
    // WRITE  | one-cycle valid-RAM set strobe
    // DONE   | one-cycle done pulse qualified by hit/err

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        CHECK,
        FETCH,
        WRITE,
        DONE
    } state_t;

    localparam logic [7:0] TIMER_LOAD = 8'(TIMEOUT_CYC - 1);

    state_t     state;
    state_t     stateNext;
    logic [9:0] addrQ;
    logic [1:0] sizeQ;
    logic [7:0] timerQ;
    logic [7:0] timerNext;
    logic       loadReq;
    logic       hitNext;
    logic       errNext;
    logic [3:0] sizeMask;

    always_comb begin
        case (sizeQ)
            2'd0:    sizeMask = 4'b0001;
            2'd1:    sizeMask = 4'b0011;
            default: sizeMask = 4'b1111;
        endcase
    end

    always_comb begin
        stateNext = state;
        timerNext = timerQ;
        loadReq   = 1'b0;
        hitNext   = 1'b0;
        errNext   = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    loadReq = 1'b1;
                    if (req_size == 2'd3) begin
                        stateNext = DONE;
                        errNext   = 1'b1;
                    end else begin
                        stateNext = LOOKUP;
                    end
                end
            end
            LOOKUP: stateNext = CHECK;
            CHECK: begin
                if ((vr_valid & sizeMask) == sizeMask) begin
                    stateNext = DONE;
                    hitNext   = 1'b1;
                end else begin
                    stateNext = FETCH;
                    timerNext = TIMER_LOAD;
                end
            end
            FETCH: begin
                // ack takes priority over the terminal count on the same edge
                if (mem_ack) begin
                    stateNext = WRITE;
                end else if (timerQ == 8'd0) begin
                    stateNext = DONE;
                    errNext   = 1'b1;
                end else begin
                    timerNext = timerQ - 8'd1;
                end
            end
            WRITE:   stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            addrQ     <= '0;
            sizeQ     <= '0;
            timerQ    <= '0;
            req_ready <= 1'b1;
            vr_write  <= 1'b0;
            mem_req   <= 1'b0;
            done      <= 1'b0;
            hit       <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= stateNext;
            timerQ    <= timerNext;
            if (loadReq) begin
                addrQ <= req_addr;
                sizeQ <= req_size;
            end
            req_ready <= (stateNext == IDLE);
            vr_write  <= (stateNext == WRITE);
            mem_req   <= (stateNext == FETCH);
            done      <= (stateNext == DONE);
            hit       <= hitNext;
            err       <= errNext;
        end
    end

    assign vr_addr  = addrQ;
    assign vr_size  = sizeQ;
    assign mem_addr = addrQ;
    assign mem_size = sizeQ;

`ifdef LOAD_FILL_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (done && hit && (hit_cnt != 16'hFFFF)) begin
                hit_cnt <= hit_cnt + 16'd1;
            end
            if (done && !hit && !err && (miss_cnt != 16'hFFFF)) begin
                miss_cnt <= miss_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
